// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and vector types for the MAC array sequencer
package mac_pkg;

   localparam int ARR_N  = 4;
   localparam int ELEM_N = ARR_N * ARR_N;
   localparam int OP_W   = 16;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef logic [ARR_N-1:0][OP_W-1:0]    opvec_t;
   typedef logic [ELEM_N-1:0][PROD_W-1:0] prodvec_t;

endpackage

// File: rtl/mac_acc_bank.sv
// rtl/mac_acc_bank.sv - sixteen unsigned accumulators with clear and enable
module mac_acc_bank
   import mac_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        en,
   input  prodvec_t                    prods,
   output logic [ELEM_N-1:0][ACC_W-1:0] sums
);

   // Clear wins over accumulate so a new job always starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sums <= '0;
      end else if (clr) begin
         sums <= '0;
      end else if (en) begin
         for (int n = 0; n < ELEM_N; n++) begin
            sums[n] <= sums[n] + ACC_W'(prods[n]);
         end
      end
   end

endmodule

// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - job sequencer feeding the 4x4 multiplier array and summing its products
module mac_array_seq
   import mac_pkg::*;
#(
   parameter int KLEN_W = 8,
   parameter int ACC_W  = 40
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [KLEN_W-1:0]             job_klen,
   input  logic                          op_valid,
   output logic                          op_ready,
   input  logic [ARR_N-1:0][OP_W-1:0]    op_wts,
   input  logic [ARR_N-1:0][OP_W-1:0]    op_ips,
   output logic [ARR_N-1:0][OP_W-1:0]    arr_wts,
   output logic [ARR_N-1:0][OP_W-1:0]    arr_ips,
   input  logic [ELEM_N-1:0][PROD_W-1:0] arr_ops,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [ELEM_N-1:0][ACC_W-1:0]  res_acc,
   output logic                          busy
);

   state_t             state;
   state_t             state_nxt;
   logic [KLEN_W-1:0]  rem;
   logic               arr_vld;
   logic               job_acc;
   logic               beat_acc;

   assign job_acc  = (state == ST_IDLE) && job_valid;
   assign beat_acc = (state == ST_RUN) && op_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a zero-length job skips straight to DONE; the last beat goes through one DRAIN cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (job_acc) begin
               state_nxt = (job_klen == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (beat_acc && (rem == KLEN_W'(1))) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs are pure functions of the current state.
   always_comb begin
      job_ready = 1'b0;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            job_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_RUN: begin
            op_ready = 1'b1;
         end
         ST_DONE: begin
            res_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Operand registers hold their last value across gaps; arr_vld marks a fresh beat for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem     <= '0;
         arr_wts <= '0;
         arr_ips <= '0;
         arr_vld <= 1'b0;
      end else begin
         arr_vld <= 1'b0;
         if (job_acc) begin
            rem <= job_klen;
         end
         if (beat_acc) begin
            arr_wts <= op_wts;
            arr_ips <= op_ips;
            arr_vld <= 1'b1;
            rem     <= rem - KLEN_W'(1);
         end
      end
   end

   mac_acc_bank #(
      .ACC_W (ACC_W)
   ) u_acc_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (job_acc),
      .en    (arr_vld),
      .prods (arr_ops),
      .sums  (res_acc)
   );

endmodule

// File: tb/tb_mac_array_seq.sv
// tb/tb_mac_array_seq.sv - randomized self-checking bench for mac_array_seq
module tb_mac_array_seq;

   localparam int KLEN_W = 8;
   localparam int ACC_W  = 40;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  job_valid;
   logic                  job_ready;
   logic [KLEN_W-1:0]     job_klen;
   logic                  op_valid;
   logic                  op_ready;
   logic [3:0][15:0]      op_wts;
   logic [3:0][15:0]      op_ips;
   logic [3:0][15:0]      arr_wts;
   logic [3:0][15:0]      arr_ips;
   logic [15:0][31:0]     arr_ops;
   logic                  res_valid;
   logic                  res_ready;
   logic [15:0][ACC_W-1:0] res_acc;
   logic                  busy;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_acc [16];
   int          gapq [$];
   int          data_mode;

   always #5 clk = ~clk;

   // Multiplier array: element 4*i+j = wts[i]*ips[j], combinational.
   always_comb begin
      arr_ops = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            arr_ops[4*i+j] = 32'(arr_wts[i]) * 32'(arr_ips[j]);
         end
      end
   end

   mac_array_seq #(
      .KLEN_W (KLEN_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .job_valid (job_valid),
      .job_ready (job_ready),
      .job_klen  (job_klen),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_wts    (op_wts),
      .op_ips    (op_ips),
      .arr_wts   (arr_wts),
      .arr_ips   (arr_ips),
      .arr_ops   (arr_ops),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_acc   (res_acc),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic make_beat(output logic [3:0][15:0] w, output logic [3:0][15:0] x);
      for (int i = 0; i < 4; i++) begin
         case (data_mode)
            1: begin
               w[i] = 16'(i + 1);
               x[i] = 16'(i + 5);
            end
            2: begin
               w[i] = 16'hFFFF;
               x[i] = 16'hFFFF;
            end
            default: begin
               w[i] = 16'($urandom);
               x[i] = 16'($urandom);
            end
         endcase
      end
   endtask

   // One full job: accept, beats with gaps, latency checks, result hold, handshake.
   task automatic do_job(input int klen, input int max_gap, input int hold);
      logic [3:0][15:0] w;
      logic [3:0][15:0] x;
      int gap;
      for (int n = 0; n < 16; n++) exp_acc[n] = 64'd0;

      @(negedge clk);
      check("job_ready_idle", {63'd0, job_ready}, 64'd1);
      job_valid = 1'b1;
      job_klen  = KLEN_W'(klen);
      @(negedge clk);
      job_valid = 1'b0;
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      check("job_ready_low", {63'd0, job_ready}, 64'd0);

      if (klen == 0) begin
         check("k0_res_valid", {63'd0, res_valid}, 64'd1);
         check("k0_op_ready", {63'd0, op_ready}, 64'd0);
      end else begin
         for (int b = 0; b < klen; b++) begin
            gap = (gapq.size() > 0) ? gapq.pop_front() : int'($urandom_range(0, max_gap));
            repeat (gap) begin
               check("op_ready_gap", {63'd0, op_ready}, 64'd1);
               @(negedge clk);
            end
            make_beat(w, x);
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  exp_acc[4*i+j] += 64'(w[i]) * 64'(x[j]);
            op_valid = 1'b1;
            op_wts   = w;
            op_ips   = x;
            check("op_ready_beat", {63'd0, op_ready}, 64'd1);
            @(negedge clk);
            op_valid = 1'b0;
            check("arr_wts_reg", 64'(arr_wts), 64'(w));
         end
         check("drain_res_valid", {63'd0, res_valid}, 64'd0);
         check("drain_op_ready", {63'd0, op_ready}, 64'd0);
         @(negedge clk);
         check("done_res_valid", {63'd0, res_valid}, 64'd1);
      end

      job_valid = 1'b1;
      job_klen  = KLEN_W'($urandom_range(1, 9));
      repeat (hold) begin
         @(negedge clk);
         check("hold_res_valid", {63'd0, res_valid}, 64'd1);
         check("hold_job_ready", {63'd0, job_ready}, 64'd0);
         check("hold_acc0", 64'(res_acc[0]), exp_acc[0] & 64'hFF_FFFF_FFFF);
         check("hold_acc15", 64'(res_acc[15]), exp_acc[15] & 64'hFF_FFFF_FFFF);
      end

      for (int n = 0; n < 16; n++)
         check($sformatf("acc%0d_k%0d", n, klen), 64'(res_acc[n]), exp_acc[n] & 64'hFF_FFFF_FFFF);

      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      job_valid = 1'b0;
      check("post_hs_res_valid", {63'd0, res_valid}, 64'd0);
      check("post_hs_busy", {63'd0, busy}, 64'd0);
      check("post_hs_job_ready", {63'd0, job_ready}, 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_job_ready"}, {63'd0, job_ready}, 64'd1);
      check({tag, "_op_ready"}, {63'd0, op_ready}, 64'd0);
      check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_arr_wts"}, 64'(arr_wts), 64'd0);
      check({tag, "_arr_ips"}, 64'(arr_ips), 64'd0);
      check({tag, "_acc0"}, 64'(res_acc[0]), 64'd0);
      check({tag, "_acc15"}, 64'(res_acc[15]), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      logic [3:0][15:0] w;
      logic [3:0][15:0] x;
      rst_n     = 1'b0;
      job_valid = 1'b0;
      job_klen  = '0;
      op_valid  = 1'b0;
      op_wts    = '0;
      op_ips    = '0;
      res_ready = 1'b0;
      data_mode = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      data_mode = 1;
      do_job(1, 0, 0);

      gapq = '{0, 2, 1};
      do_job(3, 0, 0);

      data_mode = 2;
      do_job(255, 0, 1);

      data_mode = 0;
      do_job(0, 0, 2);

      data_mode = 1;
      do_job(2, 1, 6);

      // Reset in the middle of a four-beat job.
      data_mode = 0;
      @(negedge clk);
      job_valid = 1'b1;
      job_klen  = KLEN_W'(4);
      @(negedge clk);
      job_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         make_beat(w, x);
         op_valid = 1'b1;
         op_wts   = w;
         op_ips   = x;
         @(negedge clk);
      end
      op_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      do_job(1, 0, 0);

      for (int r = 0; r < 8; r++)
         do_job(int'($urandom_range(0, 12)), 3, int'($urandom_range(0, 3)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
